wb_buffer: RTL and testbench



---
 rtl/wb_buffer_pkg.sv | 8 +
 rtl/wb_buffer_if.sv | 26 ++
 rtl/wb_match.sv | 34 +++
 rtl/wb_buffer.sv | 98 +++++++++
 tb/tb_wb_buffer.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/wb_buffer_pkg.sv
// Shared register-file constants and derived widths for the writeback buffer.
package wb_buffer_pkg;
  localparam int RegLen     = 32;
  localparam int RegAddrLen = 5;

  localparam logic [RegAddrLen-1:0] X0        = '0;
  localparam logic [RegLen-1:0]     ZERO_WORD = '0;
endpackage

// File: rtl/wb_buffer_if.sv
// Push channel from MEM/WB plus the register-file write port driven by the buffer.
interface wb_buffer_if
  import wb_buffer_pkg::*;
#(
  parameter int REG_LEN      = RegLen,
  parameter int REG_ADDR_LEN = RegAddrLen
);
  logic                    in_valid_i;
  logic                    in_ready_o;
  logic [REG_ADDR_LEN-1:0] in_addr_i;
  logic [REG_LEN-1:0]      in_data_i;
  logic                    drain_en_i;
  logic                    rd_enable_o;
  logic [REG_ADDR_LEN-1:0] rd_addr_o;
  logic [REG_LEN-1:0]      rd_data_o;

  modport slave (
    input  in_valid_i, in_addr_i, in_data_i, drain_en_i,
    output in_ready_o, rd_enable_o, rd_addr_o, rd_data_o
  );

  modport master (
    output in_valid_i, in_addr_i, in_data_i, drain_en_i,
    input  in_ready_o, rd_enable_o, rd_addr_o, rd_data_o
  );
endinterface

// File: rtl/wb_match.sv
// Youngest-first address match over the occupied FIFO entries; purely combinational.
module wb_match
  import wb_buffer_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int REG_LEN      = RegLen,
  parameter int REG_ADDR_LEN = RegAddrLen,
  localparam int PW          = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]                   valid_i,
  input  logic [PW-1:0]                      head_i,
  input  logic [DEPTH-1:0][REG_ADDR_LEN-1:0] addr_i,
  input  logic [DEPTH-1:0][REG_LEN-1:0]      data_i,
  input  logic [REG_ADDR_LEN-1:0]            rs_addr_i,
  output logic                               hit_o,
  output logic [REG_LEN-1:0]                 data_o
);
  logic [PW-1:0] idx;

  // Walk oldest to youngest so the last match, the youngest, wins.
  always_comb begin
    hit_o  = 1'b0;
    data_o = REG_LEN'(ZERO_WORD);
    idx    = head_i;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_i + PW'(i);
      if (valid_i[idx] && (addr_i[idx] == rs_addr_i) &&
          (rs_addr_i != REG_ADDR_LEN'(X0))) begin
        hit_o  = 1'b1;
        data_o = data_i[idx];
      end
    end
  end
endmodule

// File: rtl/wb_buffer.sv
// In-order writeback FIFO feeding the register-file write port, with youngest-first bypass.
// Retires one entry per cycle the cycle after acceptance; ready stays high while full if draining.
module wb_buffer
  import wb_buffer_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int REG_LEN      = RegLen,
  parameter int REG_ADDR_LEN = RegAddrLen,
  localparam int PW          = $clog2(DEPTH),
  localparam int CW          = PW + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  wb_buffer_if.slave              bus,
  input  logic [REG_ADDR_LEN-1:0] rs1_addr_i,
  input  logic [REG_ADDR_LEN-1:0] rs2_addr_i,
  output logic                    rs1_hit_o,
  output logic                    rs2_hit_o,
  output logic [REG_LEN-1:0]      rs1_data_o,
  output logic [REG_LEN-1:0]      rs2_data_o,
  output logic [CW-1:0]           count_o
);
  logic [DEPTH-1:0][REG_ADDR_LEN-1:0] addr_q;
  logic [DEPTH-1:0][REG_LEN-1:0]      data_q;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          not_empty, push, pop;
  logic [DEPTH-1:0] valid_mask;
  logic [PW-1:0]    offset;

  assign not_empty       = (count_q != '0);
  assign bus.in_ready_o  = (count_q != CW'(DEPTH)) || bus.drain_en_i;
  assign bus.rd_enable_o = not_empty && bus.drain_en_i;
  assign bus.rd_addr_o   = not_empty ? addr_q[head_q] : REG_ADDR_LEN'(X0);
  assign bus.rd_data_o   = not_empty ? data_q[head_q] : REG_LEN'(ZERO_WORD);
  assign count_o         = count_q;

  // Writes to x0 complete the handshake but are never stored.
  assign push = bus.in_valid_i && bus.in_ready_o && (bus.in_addr_i != REG_ADDR_LEN'(X0));
  assign pop  = bus.rd_enable_o;

  always_comb begin
    head_d  = pop  ? head_q + PW'(1) : head_q;
    tail_d  = push ? tail_q + PW'(1) : tail_q;
    count_d = count_q;
    if (push && !pop) count_d = count_q + CW'(1);
    if (pop && !push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= bus.in_addr_i;
      data_q[tail_q] <= bus.in_data_i;
    end
  end

  // An entry is live when its distance from head is below the occupancy.
  always_comb begin
    valid_mask = '0;
    offset     = '0;
    for (int j = 0; j < DEPTH; j++) begin
      offset        = PW'(j) - head_q;
      valid_mask[j] = ({1'b0, offset} < count_q);
    end
  end

  wb_match #(.DEPTH(DEPTH), .REG_LEN(REG_LEN), .REG_ADDR_LEN(REG_ADDR_LEN)) u_match_rs1 (
    .valid_i   (valid_mask),
    .head_i    (head_q),
    .addr_i    (addr_q),
    .data_i    (data_q),
    .rs_addr_i (rs1_addr_i),
    .hit_o     (rs1_hit_o),
    .data_o    (rs1_data_o)
  );

  wb_match #(.DEPTH(DEPTH), .REG_LEN(REG_LEN), .REG_ADDR_LEN(REG_ADDR_LEN)) u_match_rs2 (
    .valid_i   (valid_mask),
    .head_i    (head_q),
    .addr_i    (addr_q),
    .data_i    (data_q),
    .rs_addr_i (rs2_addr_i),
    .hit_o     (rs2_hit_o),
    .data_o    (rs2_data_o)
  );
endmodule

// File: tb/tb_wb_buffer.sv
// Directed vector table plus hand-written full-throughput and async-reset sequences for wb_buffer.
module tb_wb_buffer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] rs1_addr_i, rs2_addr_i;
  logic       rs1_hit_o, rs2_hit_o;
  logic [31:0] rs1_data_o, rs2_data_o;
  logic [2:0] count_o;

  int total  = 0;
  int passed = 0;

  wb_buffer_if bus ();

  wb_buffer u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .rs1_addr_i (rs1_addr_i),
    .rs2_addr_i (rs2_addr_i),
    .rs1_hit_o  (rs1_hit_o),
    .rs2_hit_o  (rs2_hit_o),
    .rs1_data_o (rs1_data_o),
    .rs2_data_o (rs2_data_o),
    .count_o    (count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [4:0]  a;
    logic [31:0] d;
    logic        dr;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        rdy;
    logic        en;
    logic [4:0]  ra;
    logic [31:0] rd;
    logic [2:0]  cnt;
    logic        h1;
    logic [31:0] d1;
    logic        h2;
    logic [31:0] d2;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(input logic v, input logic [4:0] a, input logic [31:0] d,
                              input logic dr, input logic [4:0] r1, input logic [4:0] r2,
                              input logic rdy, input logic en, input logic [4:0] ra,
                              input logic [31:0] rd, input logic [2:0] cnt,
                              input logic h1, input logic [31:0] d1,
                              input logic h2, input logic [31:0] d2);
    vec_t t;
    t.v = v; t.a = a; t.d = d; t.dr = dr; t.r1 = r1; t.r2 = r2;
    t.rdy = rdy; t.en = en; t.ra = ra; t.rd = rd; t.cnt = cnt;
    t.h1 = h1; t.d1 = d1; t.h2 = h2; t.d2 = d2;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d, input logic dr);
    bus.in_valid_i = v;
    bus.in_addr_i  = a;
    bus.in_data_i  = d;
    bus.drain_en_i = dr;
  endtask

  initial begin
    //              v  a   d             dr r1 r2 | rdy en ra  rd            cnt h1 d1            h2 d2
    vecs[0]  = mk(1, 5, 32'hDEADBEEF, 1, 5, 0,   1, 0, 0,  32'h0,        0,  0, 32'h0,        0, 32'h0);
    vecs[1]  = mk(0, 0, 32'h0,        1, 5, 0,   1, 1, 5,  32'hDEADBEEF, 1,  1, 32'hDEADBEEF, 0, 32'h0);
    vecs[2]  = mk(0, 0, 32'h0,        1, 5, 0,   1, 0, 0,  32'h0,        0,  0, 32'h0,        0, 32'h0);
    vecs[3]  = mk(1, 1, 32'h1,        0, 0, 0,   1, 0, 0,  32'h0,        0,  0, 32'h0,        0, 32'h0);
    vecs[4]  = mk(1, 2, 32'h2,        0, 0, 0,   1, 0, 1,  32'h1,        1,  0, 32'h0,        0, 32'h0);
    vecs[5]  = mk(1, 3, 32'h3,        0, 0, 0,   1, 0, 1,  32'h1,        2,  0, 32'h0,        0, 32'h0);
    vecs[6]  = mk(1, 4, 32'h4,        0, 0, 0,   1, 0, 1,  32'h1,        3,  0, 32'h0,        0, 32'h0);
    vecs[7]  = mk(0, 0, 32'h0,        0, 4, 1,   0, 0, 1,  32'h1,        4,  1, 32'h4,        1, 32'h1);
    vecs[8]  = mk(0, 0, 32'h0,        1, 0, 0,   1, 1, 1,  32'h1,        4,  0, 32'h0,        0, 32'h0);
    vecs[9]  = mk(0, 0, 32'h0,        1, 0, 0,   1, 1, 2,  32'h2,        3,  0, 32'h0,        0, 32'h0);
    vecs[10] = mk(0, 0, 32'h0,        1, 0, 0,   1, 1, 3,  32'h3,        2,  0, 32'h0,        0, 32'h0);
    vecs[11] = mk(0, 0, 32'h0,        1, 0, 0,   1, 1, 4,  32'h4,        1,  0, 32'h0,        0, 32'h0);
    vecs[12] = mk(0, 0, 32'h0,        1, 0, 0,   1, 0, 0,  32'h0,        0,  0, 32'h0,        0, 32'h0);
    vecs[13] = mk(1, 7, 32'h10,       0, 7, 0,   1, 0, 0,  32'h0,        0,  0, 32'h0,        0, 32'h0);
    vecs[14] = mk(1, 7, 32'h20,       0, 7, 0,   1, 0, 7,  32'h10,       1,  1, 32'h10,       0, 32'h0);
    vecs[15] = mk(0, 0, 32'h0,        0, 7, 8,   1, 0, 7,  32'h10,       2,  1, 32'h20,       0, 32'h0);
    vecs[16] = mk(0, 0, 32'h0,        0, 0, 7,   1, 0, 7,  32'h10,       2,  0, 32'h0,        1, 32'h20);
    vecs[17] = mk(0, 0, 32'h0,        1, 7, 0,   1, 1, 7,  32'h10,       2,  1, 32'h20,       0, 32'h0);
    vecs[18] = mk(0, 0, 32'h0,        1, 7, 0,   1, 1, 7,  32'h20,       1,  1, 32'h20,       0, 32'h0);
    vecs[19] = mk(1, 0, 32'hFFFF,     1, 0, 0,   1, 0, 0,  32'h0,        0,  0, 32'h0,        0, 32'h0);
    vecs[20] = mk(0, 0, 32'h0,        1, 0, 0,   1, 0, 0,  32'h0,        0,  0, 32'h0,        0, 32'h0);

    drive(0, 0, 0, 0);
    rs1_addr_i = 0;
    rs2_addr_i = 0;
    #1;
    chk("reset rd_enable", 32'(bus.rd_enable_o), 32'd0);
    chk("reset count",     32'(count_o),         32'd0);
    chk("reset rd_addr",   32'(bus.rd_addr_o),   32'd0);
    chk("reset rd_data",   bus.rd_data_o,        32'd0);
    chk("reset rs1_hit",   32'(rs1_hit_o),       32'd0);
    #11 rst_n = 1'b1;
    #1;
    chk("post-reset in_ready", 32'(bus.in_ready_o), 32'd1);

    for (int i = 0; i < 21; i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i].v, vecs[i].a, vecs[i].d, vecs[i].dr);
      rs1_addr_i = vecs[i].r1;
      rs2_addr_i = vecs[i].r2;
      #1;
      chk($sformatf("v%0d in_ready", i),  32'(bus.in_ready_o),  32'(vecs[i].rdy));
      chk($sformatf("v%0d rd_enable", i), 32'(bus.rd_enable_o), 32'(vecs[i].en));
      chk($sformatf("v%0d rd_addr", i),   32'(bus.rd_addr_o),   32'(vecs[i].ra));
      chk($sformatf("v%0d rd_data", i),   bus.rd_data_o,        vecs[i].rd);
      chk($sformatf("v%0d count", i),     32'(count_o),         32'(vecs[i].cnt));
      chk($sformatf("v%0d rs1_hit", i),   32'(rs1_hit_o),       32'(vecs[i].h1));
      chk($sformatf("v%0d rs1_data", i),  rs1_data_o,           vecs[i].d1);
      chk($sformatf("v%0d rs2_hit", i),   32'(rs2_hit_o),       32'(vecs[i].h2));
      chk($sformatf("v%0d rs2_data", i),  rs2_data_o,           vecs[i].d2);
    end

    // Refill to full while stalled, then push and pop together for two full wraps.
    rs1_addr_i = 0;
    rs2_addr_i = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1 drive(1, 5'(i + 1), 32'(i + 1), 0);
    end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1 drive(1, 5'(8 + i), 32'h90 + 32'(i), 1);
      #1;
      chk($sformatf("full%0d in_ready", i),  32'(bus.in_ready_o),  32'd1);
      chk($sformatf("full%0d rd_enable", i), 32'(bus.rd_enable_o), 32'd1);
      chk($sformatf("full%0d count", i),     32'(count_o),         32'd4);
      chk($sformatf("full%0d rd_addr", i),   32'(bus.rd_addr_o),   (i < 4) ? 32'(i + 1) : 32'(i + 4));
      chk($sformatf("full%0d rd_data", i),   bus.rd_data_o,        (i < 4) ? 32'(i + 1) : 32'h90 + 32'(i - 4));
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1 drive(0, 0, 0, 1);
      #1;
      chk($sformatf("tail%0d rd_addr", i), 32'(bus.rd_addr_o), 32'(12 + i));
      chk($sformatf("tail%0d rd_data", i), bus.rd_data_o,      32'h90 + 32'(4 + i));
      chk($sformatf("tail%0d count", i),   32'(count_o),       32'(4 - i));
    end
    @(posedge clk);
    #1 drive(0, 0, 0, 0);
    #1;
    chk("drained count", 32'(count_o), 32'd0);

    // Queue three entries, then reset mid-cycle with drain requested.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 drive(1, (i == 0) ? 5'd3 : (i == 1) ? 5'd6 : 5'd11, 32'h33 + 32'(i), 0);
    end
    @(posedge clk);
    #1 drive(0, 0, 0, 0);
    #1;
    chk("pre-reset count", 32'(count_o), 32'd3);
    #2;
    rs1_addr_i = 6;
    bus.drain_en_i = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("arst rd_enable", 32'(bus.rd_enable_o), 32'd0);
    chk("arst count",     32'(count_o),         32'd0);
    chk("arst rd_addr",   32'(bus.rd_addr_o),   32'd0);
    chk("arst rd_data",   bus.rd_data_o,        32'd0);
    chk("arst rs1_hit",   32'(rs1_hit_o),       32'd0);
    chk("arst in_ready",  32'(bus.in_ready_o),  32'd1);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post-arst%0d rd_enable", i), 32'(bus.rd_enable_o), 32'd0);
      chk($sformatf("post-arst%0d count", i),     32'(count_o),         32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
